// File: rtl/adc_sample_capture.sv
// adc_sample_capture: takes one {ch1,ch2} pair per ADC strobe, gates it
// through an arm/trigger/length capture window and buffers the accepted pairs
// in a synchronous FIFO that the host-side reader drains.
module adc_sample_capture #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10
) (
    input  logic                CLK_200M,
    input  logic                RST_N,
    input  logic                ADC_flag,
    input  logic [DATA_W-1:0]   ADC1_DATA,
    input  logic [DATA_W-1:0]   ADC2_DATA,
    input  logic                arm,
    input  logic [1:0]          trig_mode,
    input  logic [DATA_W-1:0]   trig_level,
    input  logic [ADDR_W:0]     capt_len,
    input  logic                fifo_clr,
    input  logic                rd_en,
    output logic [2*DATA_W-1:0] rd_data,
    output logic                rd_valid,
    output logic                empty,
    output logic                full,
    output logic [ADDR_W:0]     level,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_CAPT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Input capture and window state
    logic [DATA_W-1:0] adc1_q, adc2_q;
    logic              flag_q;
    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              done_q, done_d;
    logic              ovf_q;

    // FIFO state
    logic [2*DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     level_q;
    logic [2*DATA_W-1:0] rd_data_q;
    logic                rd_valid_q;

    logic            strobe;
    logic            trig_hit;
    logic            wr_req;
    logic            ovf_clr;
    logic            rd_accept;
    logic            wr_accept;
    logic            drop;
    logic [ADDR_W:0] len_clamped;
    logic [ADDR_W:0] cnt_inc;

    assign strobe   = ADC_flag & ~flag_q;
    assign cnt_inc  = cnt_q + CNT_ONE;
    assign empty    = (level_q == '0);
    assign full     = (level_q == DEPTH_L);
    assign level    = level_q;
    assign busy     = (state_q == S_ARMED) || (state_q == S_CAPT);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // Window length is clamped into 1..DEPTH at arm time
    always_comb begin
        len_clamped = capt_len;
        if (capt_len == '0) begin
            len_clamped = CNT_ONE;
        end else if (capt_len > DEPTH_L) begin
            len_clamped = DEPTH_L;
        end
    end

    // Trigger decision on the registered ch1 sample against the previous one
    always_comb begin
        trig_hit = 1'b1;
        case (trig_mode)
            2'd1:    trig_hit = prev_valid_q && (prev_q < trig_level) && (adc1_q >= trig_level);
            2'd2:    trig_hit = prev_valid_q && (prev_q > trig_level) && (adc1_q <= trig_level);
            default: trig_hit = 1'b1;
        endcase
    end

    // Capture FSM next state; arm overrides everything, including a same-cycle strobe
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        done_d       = done_q;
        wr_req       = 1'b0;
        ovf_clr      = 1'b0;
        if (arm) begin
            state_d      = S_ARMED;
            len_d        = len_clamped;
            cnt_d        = '0;
            done_d       = 1'b0;
            prev_valid_d = 1'b0;
            ovf_clr      = 1'b1;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (strobe) begin
                        prev_d       = adc1_q;
                        prev_valid_d = 1'b1;
                        if (trig_hit) begin
                            wr_req = 1'b1;
                            cnt_d  = CNT_ONE;
                            if (len_q == CNT_ONE) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_CAPT;
                            end
                        end
                    end
                end
                S_CAPT: begin
                    if (strobe) begin
                        wr_req = 1'b1;
                        cnt_d  = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // FIFO handshake: a full FIFO still accepts a write when a read frees a slot
    always_comb begin
        rd_accept = rd_en && !empty && !fifo_clr;
        wr_accept = wr_req && !fifo_clr && (!full || rd_accept);
        drop      = wr_req && !fifo_clr && !wr_accept;
    end

    // Input registers and FSM state
    always_ff @(posedge CLK_200M or negedge RST_N) begin
        if (!RST_N) begin
            adc1_q       <= '0;
            adc2_q       <= '0;
            flag_q       <= 1'b0;
            state_q      <= S_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            adc1_q       <= ADC1_DATA;
            adc2_q       <= ADC2_DATA;
            flag_q       <= ADC_flag;
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            done_q       <= done_d;
        end
    end

    // FIFO pointers, occupancy, read port and sticky overflow
    always_ff @(posedge CLK_200M or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (fifo_clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (wr_accept) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (rd_accept) begin
                    rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                    rd_data_q <= mem_q[rd_ptr_q];
                end
                if (wr_accept && !rd_accept) begin
                    level_q <= level_q + CNT_ONE;
                end else if (rd_accept && !wr_accept) begin
                    level_q <= level_q - CNT_ONE;
                end
            end
            if (ovf_clr || fifo_clr) begin
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Sample storage; contents need no reset since pointers define validity
    always_ff @(posedge CLK_200M) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= {adc1_q, adc2_q};
        end
    end

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed bench for adc_sample_capture: vector table for trigger/window
// cases, then hand-written sequences for latency, fill/clamp/overflow,
// full-FIFO simultaneity and asynchronous reset.
`timescale 1ns/1ps
module tb_adc_sample_capture;

    logic        CLK_200M = 1'b0;
    logic        RST_N = 1'b0;
    logic        ADC_flag = 1'b0;
    logic [9:0]  ADC1_DATA = '0;
    logic [9:0]  ADC2_DATA = '0;
    logic        arm = 1'b0;
    logic [1:0]  trig_mode = '0;
    logic [9:0]  trig_level = '0;
    logic [10:0] capt_len = '0;
    logic        fifo_clr = 1'b0;
    logic        rd_en = 1'b0;
    logic [19:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [10:0] level;
    logic        busy;
    logic        done;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    adc_sample_capture #(.DATA_W(10), .ADDR_W(10)) dut (
        .CLK_200M   (CLK_200M),
        .RST_N      (RST_N),
        .ADC_flag   (ADC_flag),
        .ADC1_DATA  (ADC1_DATA),
        .ADC2_DATA  (ADC2_DATA),
        .arm        (arm),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .capt_len   (capt_len),
        .fifo_clr   (fifo_clr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 CLK_200M = ~CLK_200M;

    typedef struct packed {
        logic [1:0]      mode;
        logic [9:0]      lvl;
        logic [10:0]     len;
        logic [2:0]      n;
        logic [5:0][9:0] smp;
        logic [2:0]      first;
        logic [2:0]      cnt;
        logic            exp_done;
        logic            exp_busy;
    } vec_t;

    vec_t tv [8];

    function automatic vec_t mk(input logic [1:0] mode, input logic [9:0] lvl,
                                input logic [10:0] len, input logic [2:0] n,
                                input logic [9:0] s0, input logic [9:0] s1,
                                input logic [9:0] s2, input logic [9:0] s3,
                                input logic [9:0] s4, input logic [9:0] s5,
                                input logic [2:0] first, input logic [2:0] cnt,
                                input logic ed, input logic eb);
        vec_t v;
        v.mode = mode; v.lvl = lvl; v.len = len; v.n = n;
        v.smp[0] = s0; v.smp[1] = s1; v.smp[2] = s2;
        v.smp[3] = s3; v.smp[4] = s4; v.smp[5] = s5;
        v.first = first; v.cnt = cnt; v.exp_done = ed; v.exp_busy = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic [9:0] v);
        @(negedge CLK_200M);
        ADC1_DATA = v;
        ADC2_DATA = ~v;
        @(negedge CLK_200M);
        ADC_flag = 1'b1;
        @(negedge CLK_200M);
        ADC_flag = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] mode, input logic [9:0] lvl, input logic [10:0] len);
        @(negedge CLK_200M);
        trig_mode  = mode;
        trig_level = lvl;
        capt_len   = len;
        arm        = 1'b1;
        @(negedge CLK_200M);
        arm = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge CLK_200M);
        fifo_clr = 1'b1;
        @(negedge CLK_200M);
        fifo_clr = 1'b0;
    endtask

    task automatic pop(input string nm, input logic [9:0] ch1);
        logic [19:0] exp;
        exp = {ch1, ~ch1};
        @(negedge CLK_200M);
        rd_en = 1'b1;
        @(negedge CLK_200M);
        rd_en = 1'b0;
        chk({nm, " rd_valid"}, rd_valid, 1);
        chk({nm, " rd_data"}, rd_data, exp);
    endtask

    initial begin
        int vcount;
        logic [9:0] v;

        tv[0] = mk(2'd0, 10'd0,   11'd4, 3'd6, 10'd0,   10'd1,  10'd2,   10'd3,   10'd4,  10'd5, 3'd0, 3'd4, 1'b1, 1'b0);
        tv[1] = mk(2'd1, 10'd100, 11'd2, 3'd5, 10'd50,  10'd90, 10'd120, 10'd130, 10'd80, 10'd0, 3'd2, 3'd2, 1'b1, 1'b0);
        tv[2] = mk(2'd2, 10'd100, 11'd1, 3'd4, 10'd80,  10'd70, 10'd150, 10'd100, 10'd0,  10'd0, 3'd3, 3'd1, 1'b1, 1'b0);
        tv[3] = mk(2'd3, 10'd500, 11'd1, 3'd3, 10'd7,   10'd8,  10'd9,   10'd0,   10'd0,  10'd0, 3'd0, 3'd1, 1'b1, 1'b0);
        tv[4] = mk(2'd0, 10'd0,   11'd0, 3'd2, 10'd33,  10'd34, 10'd0,   10'd0,   10'd0,  10'd0, 3'd0, 3'd1, 1'b1, 1'b0);
        tv[5] = mk(2'd1, 10'd100, 11'd3, 3'd4, 10'd200, 10'd150,10'd120, 10'd110, 10'd0,  10'd0, 3'd0, 3'd0, 1'b0, 1'b1);
        tv[6] = mk(2'd2, 10'd100, 11'd3, 3'd4, 10'd150, 10'd100,10'd60,  10'd40,  10'd0,  10'd0, 3'd1, 3'd3, 1'b1, 1'b0);
        tv[7] = mk(2'd0, 10'd0,   11'd5, 3'd3, 10'd1,   10'd2,  10'd3,   10'd0,   10'd0,  10'd0, 3'd0, 3'd3, 1'b0, 1'b1);

        // Reset state
        repeat (2) @(negedge CLK_200M);
        chk("reset empty", empty, 1);
        chk("reset level", level, 0);
        chk("reset full", full, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset overflow", overflow, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_data", rd_data, 0);
        RST_N = 1'b1;

        // Strobes while IDLE must not write
        strobe(10'd9);
        @(negedge CLK_200M);
        chk("idle no write", level, 0);

        // Table-driven trigger/window vectors
        for (int i = 0; i < 8; i++) begin
            do_clr();
            do_arm(tv[i].mode, tv[i].lvl, tv[i].len);
            chk($sformatf("v%0d busy after arm", i), busy, 1);
            for (int k = 0; k < int'(tv[i].n); k++) begin
                strobe(tv[i].smp[k]);
            end
            @(negedge CLK_200M);
            chk($sformatf("v%0d level", i), level, tv[i].cnt);
            chk($sformatf("v%0d empty", i), empty, (tv[i].cnt == 0) ? 1 : 0);
            chk($sformatf("v%0d done", i), done, tv[i].exp_done);
            chk($sformatf("v%0d busy", i), busy, tv[i].exp_busy);
            chk($sformatf("v%0d overflow", i), overflow, 0);
            for (int k = 0; k < int'(tv[i].cnt); k++) begin
                pop($sformatf("v%0d word%0d", i, k), tv[i].smp[int'(tv[i].first) + k]);
            end
            $display("vector %0d mode=%0d len=%0d words=%0d checked", i, tv[i].mode, tv[i].len, tv[i].cnt);
        end

        // Read latency: 3 words, rd_en held for 5 clocks
        do_clr();
        do_arm(2'd0, 10'd0, 11'd3);
        strobe(10'd11);
        strobe(10'd12);
        strobe(10'd13);
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK_200M);
            if (i > 0) begin
                chk($sformatf("lat rd_valid c%0d", i), rd_valid, (i <= 3) ? 1 : 0);
                if (rd_valid) begin
                    v = 10'(10 + i);
                    chk($sformatf("lat rd_data c%0d", i), rd_data, {v, ~v});
                    vcount++;
                end
            end
            rd_en = (i < 5);
        end
        chk("lat pulse count", vcount, 3);
        chk("lat empty", empty, 1);
        chk("lat rd_data hold", rd_data, {10'd13, ~10'd13});
        $display("latency sequence: %0d rd_valid pulses", vcount);

        // Prefill 6 words, then a clamped window (1030 -> 1024) overflows
        do_clr();
        do_arm(2'd0, 10'd0, 11'd6);
        for (int k = 0; k < 6; k++) strobe(10'(10'h3F0 + k));
        do_arm(2'd0, 10'd0, 11'd1030);
        for (int k = 1; k <= 1024; k++) begin
            strobe(10'(k));
            if (k == 1018) begin
                @(negedge CLK_200M);
                chk("fill full at 1018", full, 1);
                chk("fill no overflow yet", overflow, 0);
            end
            if (k == 1023) begin
                @(negedge CLK_200M);
                chk("clamp done before 1024", done, 0);
                chk("clamp busy before 1024", busy, 1);
            end
        end
        @(negedge CLK_200M);
        chk("clamp done at 1024", done, 1);
        chk("clamp busy at 1024", busy, 0);
        chk("ovf level", level, 1024);
        chk("ovf full", full, 1);
        chk("ovf overflow", overflow, 1);
        $display("fill sequence: level=%0d overflow=%0d", level, overflow);

        // Full FIFO: read and strobe on the same cycle
        do_arm(2'd0, 10'd0, 11'd2);
        chk("arm clears overflow", overflow, 0);
        chk("arm clears done", done, 0);
        @(negedge CLK_200M);
        ADC1_DATA = 10'h155;
        ADC2_DATA = ~10'h155;
        @(negedge CLK_200M);
        ADC_flag = 1'b1;
        rd_en    = 1'b1;
        @(negedge CLK_200M);
        ADC_flag = 1'b0;
        rd_en    = 1'b0;
        chk("simul rd_valid", rd_valid, 1);
        chk("simul rd_data", rd_data, {10'h3F0, ~10'h3F0});
        @(negedge CLK_200M);
        chk("simul level", level, 1024);
        chk("simul full", full, 1);
        chk("simul overflow", overflow, 0);
        $display("simultaneous read/write at full: level=%0d", level);

        // Drain everything and check order across the pointer wrap
        for (int k = 1; k < 6; k++) pop($sformatf("drain pre%0d", k), 10'(10'h3F0 + k));
        for (int k = 1; k <= 1018; k++) pop($sformatf("drain s%0d", k), 10'(k));
        pop("drain last", 10'h155);
        @(negedge CLK_200M);
        chk("drain empty", empty, 1);
        @(negedge CLK_200M);
        rd_en = 1'b1;
        @(negedge CLK_200M);
        rd_en = 1'b0;
        chk("read while empty no valid", rd_valid, 0);
        $display("drain sequence: 1024 words read");

        // fifo_clr beats a same-cycle strobe write
        do_arm(2'd0, 10'd0, 11'd4);
        strobe(10'd21);
        @(negedge CLK_200M);
        ADC1_DATA = 10'd22;
        @(negedge CLK_200M);
        ADC_flag = 1'b1;
        fifo_clr = 1'b1;
        @(negedge CLK_200M);
        ADC_flag = 1'b0;
        fifo_clr = 1'b0;
        @(negedge CLK_200M);
        chk("clr level", level, 0);
        chk("clr busy kept", busy, 1);
        $display("fifo_clr priority sequence checked");

        // Asynchronous reset mid-window
        strobe(10'd23);
        @(negedge CLK_200M);
        chk("pre-reset level", level, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("areset empty", empty, 1);
        chk("areset level", level, 0);
        chk("areset busy", busy, 0);
        chk("areset done", done, 0);
        chk("areset overflow", overflow, 0);
        chk("areset rd_data", rd_data, 0);
        @(negedge CLK_200M);
        RST_N = 1'b1;
        strobe(10'd24);
        @(negedge CLK_200M);
        chk("post-reset idle", level, 0);
        $display("async reset sequence checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
